// File: rtl/pi_regulator_pkg.sv
// Shared definitions for the PI regulator: mode encodings, saturation flag
// indices and width helpers derived from the regulator parameters.
package pi_regulator_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_HOLD = 2'b10
    } mode_e;

    localparam int SAT_HI = 1;
    localparam int SAT_LO = 0;

    // The reserved encoding 2'b11 behaves exactly like HOLD.
    function automatic mode_e decode_mode(input logic [1:0] m);
        mode_e r;
        r = MODE_HOLD;
        if (m == 2'b00) begin
            r = MODE_OFF;
        end else if (m == 2'b01) begin
            r = MODE_RUN;
        end
        return r;
    endfunction

    function automatic int err_width(input int adc_w);
        return adc_w + 1;
    endfunction

    function automatic int prod_width(input int gain_w, input int adc_w);
        return gain_w + adc_w + 1;
    endfunction

endpackage

// File: rtl/pi_regulator_sat_clamp.sv
// Combinational signed clamp of a wide value into [lo, hi] with hi/lo flags.
// An inverted window (lo > hi) yields lo with both flags raised.
module sat_clamp #(
    parameter int IN_WIDTH  = 37,
    parameter int OUT_WIDTH = 36
) (
    input  logic signed [IN_WIDTH-1:0]  in_i,
    input  logic signed [OUT_WIDTH-1:0] lo_i,
    input  logic signed [OUT_WIDTH-1:0] hi_i,
    output logic signed [OUT_WIDTH-1:0] out_o,
    output logic                        hi_o,
    output logic                        lo_o
);

    logic signed [IN_WIDTH-1:0] lo_ext;
    logic signed [IN_WIDTH-1:0] hi_ext;

    // IN_WIDTH is always strictly wider than OUT_WIDTH at every use site.
    assign lo_ext = {{(IN_WIDTH-OUT_WIDTH){lo_i[OUT_WIDTH-1]}}, lo_i};
    assign hi_ext = {{(IN_WIDTH-OUT_WIDTH){hi_i[OUT_WIDTH-1]}}, hi_i};

    always_comb begin
        out_o = in_i[OUT_WIDTH-1:0];
        hi_o  = 1'b0;
        lo_o  = 1'b0;
        if (lo_ext > hi_ext) begin
            out_o = lo_i;
            hi_o  = 1'b1;
            lo_o  = 1'b1;
        end else if (in_i > hi_ext) begin
            out_o = hi_i;
            hi_o  = 1'b1;
        end else if (in_i < lo_ext) begin
            out_o = lo_i;
            lo_o  = 1'b1;
        end
    end

endmodule

// File: rtl/pi_regulator.sv
// Signed PI regulator between the ADC capture path and the DAC: error per
// sample, P/I gains, saturating integrator with anti-windup, clamped output.
module pi_regulator
    import pi_regulator_pkg::*;
#(
    parameter int ADC_WIDTH  = 18,
    parameter int DAC_WIDTH  = 16,
    parameter int GAIN_WIDTH = 16,
    parameter int GAIN_FRAC  = 12,
    parameter int ACC_WIDTH  = 36
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         adc_valid,
    input  logic signed [ADC_WIDTH-1:0]  adc_data,
    input  logic signed [ADC_WIDTH-1:0]  setpoint,
    input  logic [1:0]                   mode,
    input  logic                         clear,
    input  logic signed [GAIN_WIDTH-1:0] kp,
    input  logic signed [GAIN_WIDTH-1:0] ki,
    input  logic signed [DAC_WIDTH-1:0]  out_min,
    input  logic signed [DAC_WIDTH-1:0]  out_max,
    output logic signed [DAC_WIDTH-1:0]  dac_data,
    output logic                         dac_valid,
    output logic [1:0]                   saturated
);

    localparam int EW = err_width(ADC_WIDTH);
    localparam int PW = prod_width(GAIN_WIDTH, ADC_WIDTH);
    localparam int SW = ACC_WIDTH + 1;
    localparam int UW = SW - GAIN_FRAC;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Handshake: adc_valid is a level whose rising edge launches one sample;
    // dac_valid is a one-cycle push with no backpressure, 3 cycles later.
    logic                         adc_valid_q;
    logic                         strobe;
    mode_e                        mode_live;
    logic                         v0_q, v1_q;
    mode_e                        mode0_q, mode1_q;
    logic signed [EW-1:0]         e_d, e0_q;
    logic signed [PW-1:0]         kp_x, ki_x, e_x;
    logic signed [PW-1:0]         p_d, di_d, p1_q, di1_q;
    logic signed [SW-1:0]         acc_sum;
    logic signed [ACC_WIDTH-1:0]  acc_upd, acc_d, acc_q;
    logic [1:0]                   acc_flags_unused;
    logic                         di_pos, di_neg, hold_int;
    logic signed [SW-1:0]         u_sum;
    logic signed [UW-1:0]         u_val;
    logic signed [DAC_WIDTH-1:0]  clamp_out;
    logic                         clamp_hi, clamp_lo;
    logic signed [DAC_WIDTH-1:0]  dac_d, dac_q;
    logic [1:0]                   sat_d, sat_q;
    logic                         dac_valid_d, dac_valid_q;

    assign strobe    = adc_valid & ~adc_valid_q;
    assign mode_live = decode_mode(mode);

    assign e_d  = {setpoint[ADC_WIDTH-1], setpoint} - {adc_data[ADC_WIDTH-1], adc_data};
    assign kp_x = {{(PW-GAIN_WIDTH){kp[GAIN_WIDTH-1]}}, kp};
    assign ki_x = {{(PW-GAIN_WIDTH){ki[GAIN_WIDTH-1]}}, ki};
    assign e_x  = {{(PW-EW){e0_q[EW-1]}}, e0_q};
    assign p_d  = kp_x * e_x;
    assign di_d = ki_x * e_x;

    assign acc_sum = {acc_q[ACC_WIDTH-1], acc_q} + {{(SW-PW){di1_q[PW-1]}}, di1_q};

    sat_clamp #(
        .IN_WIDTH (SW),
        .OUT_WIDTH(ACC_WIDTH)
    ) u_acc_sat (
        .in_i (acc_sum),
        .lo_i (ACC_MIN),
        .hi_i (ACC_MAX),
        .out_o(acc_upd),
        .hi_o (acc_flags_unused[1]),
        .lo_o (acc_flags_unused[0])
    );

    // Integrating further into an output limit the last update already hit
    // only winds the accumulator up, so such steps are skipped.
    assign di_pos   = ~di1_q[PW-1] & (|di1_q);
    assign di_neg   = di1_q[PW-1];
    assign hold_int = (sat_q[SAT_HI] & di_pos) | (sat_q[SAT_LO] & di_neg);

    always_comb begin
        acc_d = acc_q;
        if (clear || (mode_live == MODE_OFF)) begin
            acc_d = '0;
        end else if (v1_q && (mode1_q == MODE_RUN) && !hold_int) begin
            acc_d = acc_upd;
        end
    end

    // The output uses the accumulator value being written this cycle, so the
    // current sample's integral step (or a concurrent clear) is reflected.
    assign u_sum = {acc_d[ACC_WIDTH-1], acc_d} + {{(SW-PW){p1_q[PW-1]}}, p1_q};
    assign u_val = (mode1_q == MODE_OFF) ? '0 : u_sum[SW-1:GAIN_FRAC];

    sat_clamp #(
        .IN_WIDTH (UW),
        .OUT_WIDTH(DAC_WIDTH)
    ) u_out_clamp (
        .in_i (u_val),
        .lo_i (out_min),
        .hi_i (out_max),
        .out_o(clamp_out),
        .hi_o (clamp_hi),
        .lo_o (clamp_lo)
    );

    always_comb begin
        dac_d       = dac_q;
        sat_d       = sat_q;
        dac_valid_d = 1'b0;
        if (v1_q && (mode1_q != MODE_HOLD)) begin
            dac_d       = clamp_out;
            sat_d       = {clamp_hi, clamp_lo};
            dac_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adc_valid_q <= 1'b1;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            mode0_q     <= MODE_OFF;
            mode1_q     <= MODE_OFF;
            e0_q        <= '0;
            p1_q        <= '0;
            di1_q       <= '0;
            acc_q       <= '0;
            dac_q       <= '0;
            sat_q       <= '0;
            dac_valid_q <= 1'b0;
        end else begin
            adc_valid_q <= adc_valid;
            v0_q        <= strobe;
            v1_q        <= v0_q;
            if (strobe) begin
                e0_q    <= e_d;
                mode0_q <= mode_live;
            end
            if (v0_q) begin
                p1_q    <= p_d;
                di1_q   <= di_d;
                mode1_q <= mode0_q;
            end
            acc_q       <= acc_d;
            dac_q       <= dac_d;
            sat_q       <= sat_d;
            dac_valid_q <= dac_valid_d;
        end
    end

    assign dac_data  = dac_q;
    assign dac_valid = dac_valid_q;
    assign saturated = sat_q;

endmodule

// File: tb/tb_pi_regulator.sv
// Self-checking bench for pi_regulator: directed scenarios plus randomized
// groups, all predicted by a per-sample arithmetic reference model.
module tb_pi_regulator;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int GW = 16;
    localparam longint ACC_MAX = (longint'(1) <<< 35) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< 35);

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 adc_valid;
    logic signed [AW-1:0] adc_data;
    logic signed [AW-1:0] setpoint;
    logic [1:0]           mode;
    logic                 clear;
    logic signed [GW-1:0] kp;
    logic signed [GW-1:0] ki;
    logic signed [DW-1:0] out_min;
    logic signed [DW-1:0] out_max;
    logic signed [DW-1:0] dac_data;
    logic                 dac_valid;
    logic [1:0]           saturated;

    int tests = 0;
    int fails = 0;

    longint     m_acc;
    logic [1:0] m_sat;
    int         cur_mode;
    longint     cur_kp, cur_ki, cur_min, cur_max;

    logic [63:0]          exp_q[$];
    logic [1:0]           exp_sat_q[$];
    logic signed [AW-1:0] sp_a[16];
    logic signed [AW-1:0] ad_a[16];

    always #5 clk = ~clk;

    pi_regulator dut (
        .clk      (clk),
        .resetn   (resetn),
        .adc_valid(adc_valid),
        .adc_data (adc_data),
        .setpoint (setpoint),
        .mode     (mode),
        .clear    (clear),
        .kp       (kp),
        .ki       (ki),
        .out_min  (out_min),
        .out_max  (out_max),
        .dac_data (dac_data),
        .dac_valid(dac_valid),
        .saturated(saturated)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint floor_div4096(input longint v);
        longint q;
        q = v / 4096;
        if ((v % 4096) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    // Reference: one call per sample, in sample order, from the rules alone.
    task automatic model_sample(input longint e, input bit clr, output bit has_out);
        longint p, di, v, u, o;
        logic [1:0] s;
        has_out = 1'b0;
        if (clr) m_acc = 0;
        if (cur_mode == 2 || cur_mode == 3) return;
        p  = cur_kp * e;
        di = cur_ki * e;
        if (cur_mode == 0) begin
            m_acc = 0;
            v = 0;
        end else begin
            if (!clr && !((m_sat[1] && di > 0) || (m_sat[0] && di < 0))) begin
                m_acc = m_acc + di;
                if (m_acc > ACC_MAX) m_acc = ACC_MAX;
                if (m_acc < ACC_MIN) m_acc = ACC_MIN;
            end
            v = p + m_acc;
        end
        u = floor_div4096(v);
        if (cur_min > cur_max) begin
            o = cur_min; s = 2'b11;
        end else if (u > cur_max) begin
            o = cur_max; s = 2'b10;
        end else if (u < cur_min) begin
            o = cur_min; s = 2'b01;
        end else begin
            o = u; s = 2'b00;
        end
        m_sat = s;
        exp_q.push_back(o);
        exp_sat_q.push_back(s);
        has_out = 1'b1;
    endtask

    task automatic set_cfg(input int md, input int kpv, input int kiv, input int mn, input int mx);
        mode = md[1:0];
        kp = kpv[15:0];
        ki = kiv[15:0];
        out_min = mn[15:0];
        out_max = mx[15:0];
        cur_mode = md;
        cur_kp = kpv;
        cur_ki = kiv;
        cur_min = mn;
        cur_max = mx;
        if (md == 0) m_acc = 0;
    endtask

    task automatic fill(input int n, input int err);
        int a, b;
        for (int i = 0; i < n; i++) begin
            a = int'($urandom_range(0, 2000)) - 1000;
            b = a + err;
            ad_a[i] = a[AW-1:0];
            sp_a[i] = b[AW-1:0];
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        m_acc = 0;
    endtask

    // Launches n samples gap cycles apart and checks dac_valid every cycle;
    // sample clr_idx gets a clear pulse in the cycle it is integrated.
    task automatic run_samples(input int n, input int gap, input int clr_idx);
        bit     ev[128];
        int     clr_cycle;
        bit     h;
        longint e;
        clr_cycle = -1;
        for (int i = 0; i < 128; i++) ev[i] = 1'b0;
        for (int c = 0; c < n * gap + 4; c++) begin
            @(posedge clk); #1;
            chk("dac_valid", 64'(dac_valid), 64'(ev[c]));
            if (ev[c]) begin
                chk("dac_data", 64'(dac_data), exp_q.pop_front());
                chk("saturated", 64'(saturated), 64'(exp_sat_q.pop_front()));
            end
            adc_valid = 1'b0;
            clear = 1'b0;
            if ((c % gap) == 0 && (c / gap) < n) begin
                setpoint = sp_a[c / gap];
                adc_data = ad_a[c / gap];
                adc_valid = 1'b1;
                e = longint'(sp_a[c / gap]) - longint'(ad_a[c / gap]);
                model_sample(e, (c / gap) == clr_idx, h);
                if (h) ev[c + 3] = 1'b1;
                if ((c / gap) == clr_idx) clr_cycle = c + 2;
            end
            if (c == clr_cycle) clear = 1'b1;
        end
    endtask

    initial begin
        int md, kpv, kiv, mn, mx, t, n, gap, ci, a, b;
        resetn = 1'b0;
        adc_valid = 1'b1;
        clear = 1'b0;
        setpoint = '0;
        adc_data = '0;
        set_cfg(1, 0, 0, -32768, 32767);
        m_acc = 0;
        m_sat = 2'b00;

        // Reset release with adc_valid held high: no sample may launch.
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("reset_no_valid", 64'(dac_valid), 64'(0));
        end
        chk("reset_dac_data", 64'(dac_data), 64'(0));
        chk("reset_saturated", 64'(saturated), 64'(0));
        adc_valid = 1'b0;
        @(posedge clk); #1;

        // P-only.
        set_cfg(1, 4096, 0, -32768, 32767);
        sp_a[0] = 18'sd1000;
        ad_a[0] = 18'sd400;
        run_samples(1, 4, -1);
        chk("p_only", 64'(dac_data), 64'(600));

        // Pure integral ramp.
        set_cfg(1, 0, 4096, -32768, 32767);
        fill(5, 100);
        run_samples(5, 4, -1);
        chk("integral_ramp", 64'(dac_data), 64'(500));

        // Anti-windup against the upper output clamp, then recovery.
        pulse_clear();
        set_cfg(1, 0, 4096, -32768, 250);
        fill(5, 100);
        run_samples(5, 4, -1);
        chk("windup_clamped", 64'(dac_data), 64'(250));
        chk("windup_sat", 64'(saturated), 64'(2'b10));
        fill(1, -100);
        run_samples(1, 4, -1);
        chk("windup_recover", 64'(dac_data), 64'(200));
        chk("windup_recover_sat", 64'(saturated), 64'(0));

        // HOLD freezes everything; 2'b11 behaves as HOLD; RUN resumes.
        set_cfg(1, 0, 4096, -32768, 32767);
        pulse_clear();
        fill(5, 100);
        run_samples(5, 4, -1);
        set_cfg(2, 0, 4096, -32768, 32767);
        fill(3, 700);
        run_samples(3, 4, -1);
        chk("hold_frozen", 64'(dac_data), 64'(500));
        set_cfg(3, 0, 4096, -32768, 32767);
        fill(1, -900);
        run_samples(1, 4, -1);
        chk("mode3_hold", 64'(dac_data), 64'(500));
        set_cfg(1, 0, 4096, -32768, 32767);
        fill(1, 10);
        run_samples(1, 4, -1);
        chk("hold_resume", 64'(dac_data), 64'(510));

        // clear coinciding with the integration cycle gives a P-only output.
        set_cfg(1, 4096, 4096, -32768, 32767);
        fill(1, 50);
        run_samples(1, 4, 0);
        chk("clear_p_only", 64'(dac_data), 64'(50));

        // OFF outputs clamp(0) with acc forced to 0; RUN restarts bumplessly.
        set_cfg(0, 4096, 4096, 10, 200);
        fill(3, 1000);
        run_samples(3, 4, -1);
        chk("off_output", 64'(dac_data), 64'(10));
        chk("off_sat", 64'(saturated), 64'(2'b01));
        set_cfg(1, 0, 4096, 10, 200);
        fill(1, 20);
        run_samples(1, 4, -1);
        chk("off_to_run", 64'(dac_data), 64'(20));

        // Inverted clamp window.
        set_cfg(1, 4096, 0, 100, -100);
        fill(1, 5);
        run_samples(1, 4, -1);
        chk("inverted_clamp", 64'(dac_data), 64'(100));
        chk("inverted_sat", 64'(saturated), 64'(2'b11));

        // Strobes at the minimum spacing of 2 cycles.
        pulse_clear();
        set_cfg(1, 2048, 1024, -32768, 32767);
        fill(6, 0);
        for (int i = 0; i < 6; i++) begin
            a = int'($urandom_range(0, 4000)) - 2000;
            b = int'(ad_a[i]) + a;
            sp_a[i] = b[AW-1:0];
        end
        run_samples(6, 2, -1);

        // Reset in the middle of the pipeline aborts the sample.
        adc_valid = 1'b1;
        @(posedge clk); #1;
        adc_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("midreset_dac_data", 64'(dac_data), 64'(0));
        @(posedge clk); #1;
        resetn = 1'b1;
        m_acc = 0;
        m_sat = 2'b00;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("midreset_no_valid", 64'(dac_valid), 64'(0));
        end

        // Randomized groups.
        for (int g = 0; g < 12; g++) begin
            t = int'($urandom_range(0, 9));
            md = (t == 0) ? 0 : (t == 1) ? 2 : (t == 2) ? 3 : 1;
            kpv = int'($urandom_range(0, 65535)) - 32768;
            kiv = int'($urandom_range(0, 65535)) - 32768;
            if ((g % 2) == 1) begin
                kpv = kpv / 8;
                kiv = kiv / 64;
            end
            mn = int'($urandom_range(0, 65535)) - 32768;
            mx = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 7) != 0 && mn > mx) begin
                t = mn; mn = mx; mx = t;
            end
            set_cfg(md, kpv, kiv, mn, mx);
            n = int'($urandom_range(2, 8));
            gap = int'($urandom_range(2, 5));
            ci = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            for (int i = 0; i < n; i++) begin
                if ((g % 2) == 1) begin
                    a = int'($urandom_range(0, 4000)) - 2000;
                    b = a + int'($urandom_range(0, 6000)) - 3000;
                end else begin
                    a = int'($urandom_range(0, 262143));
                    b = int'($urandom_range(0, 262143));
                end
                ad_a[i] = a[AW-1:0];
                sp_a[i] = b[AW-1:0];
            end
            run_samples(n, gap, ci);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pi_regulator.md
Name: pi_regulator

Overview:
- Parametrised successor to the single-channel edge-triggered integrator: a signed proportional-integral feedback regulator.
- It sits between the ADC capture path and the DAC output in the adc-dac-bram-feedback design.
- Per ADC sample it computes error = setpoint − adc_data, applies programmable P and I gains with a saturating accumulator, conditional-integration anti-windup and an output clamp, and drives dac_data.
- Run, hold and track/off modes are selected by software over AXI-lite registers.

Parameters:
- ADC_WIDTH, 18, signed width of adc_data and setpoint
- DAC_WIDTH, 16, signed width of dac_data, out_min and out_max
- GAIN_WIDTH, 16, signed width of kp and ki
- GAIN_FRAC, 12, fractional bits of kp/ki (4096 = 1.0 at default)
- ACC_WIDTH, 36, signed integrator accumulator width; must be ≥ GAIN_WIDTH+ADC_WIDTH+1

Ports:
- clk, in, 1: single clock; every register is on its rising edge
- resetn, in, 1: asynchronous, active-low reset
- adc_valid, in, 1: sample strobe; a rising edge marks a new sample
- adc_data, in, ADC_WIDTH: signed measurement
- setpoint, in, ADC_WIDTH: signed target
- mode, in, 2: 00 OFF, 01 RUN, 10 HOLD, 11 treated as HOLD
- clear, in, 1: single-cycle accumulator clear
- kp, in, GAIN_WIDTH: signed proportional gain
- ki, in, GAIN_WIDTH: signed integral gain
- out_min, in, DAC_WIDTH: signed lower clamp
- out_max, in, DAC_WIDTH: signed upper clamp
- dac_data, out, DAC_WIDTH: signed regulator output
- dac_valid, out, 1: one-cycle pulse on each dac_data update
- saturated, out, 2: bit1 = clamped high, bit0 = clamped low; reflects the last update

Behaviour:
- Reset: all pipeline registers, the accumulator, dac_data, dac_valid and saturated clear to 0.
- The adc_valid edge register resets to 1, so adc_valid held high through reset release produces no sample.
- Sample strobe s = adc_valid & ~adc_valid_q; only rising edges count.
- Pipeline (fixed latency: dac_valid pulses exactly 3 cycles after the cycle in which s=1):
  - S0, when s=1: register e = sext(setpoint) − sext(adc_data), ADC_WIDTH+1 bits, exact. Register the current mode alongside the sample.
  - S1: register p = kp*e and di = ki*e as full-precision signed products. kp/ki are sampled at this stage.
  - S2: acc <= sat_ACC(acc + di), saturating to the ACC_WIDTH signed max/min, never wrapping.
    - Anti-windup: acc holds if saturated[1] & di>0, or saturated[0] & di<0 (flags from the previous update).
  - S3: u = (p + acc) >>> GAIN_FRAC, arithmetic shift, truncation toward −inf.
    - dac_data <= clamp(u, out_min, out_max); saturated updated; dac_valid=1 for one cycle.
    - If out_min > out_max, dac_data = out_min and saturated = 2'b11.
- Modes (the mode registered with the sample governs S2/S3 of that sample):
  - RUN: as above.
  - HOLD: accumulator, dac_data and saturated frozen; no dac_valid; samples are discarded at S2.
  - OFF: accumulator forced to 0 every cycle, using the live mode input.
    - Each sample in OFF outputs clamp(0, out_min, out_max) with dac_valid; the P term is ignored.
- Mode changes:
  - OFF→RUN starts from acc=0 (bumpless start).
  - RUN→HOLD→RUN resumes from the frozen acc.
  - Samples already in flight complete under their captured mode.
- clear: acc <= 0 on the next edge, with priority over an S2 update in the same cycle.
  - A sample at S3 concurrently uses acc=0 (P-only output).
- Back-to-back strobes can be no closer than every 2 cycles (edge detect); the pipeline is fully pipelined, with no stall and no drop.
- resetn assertion mid-pipeline aborts in-flight samples immediately; there is no dac_valid until a new edge after release.

Decomposition:
- Shared header/package pi_regulator_pkg:
  - mode encodings MODE_OFF/MODE_RUN/MODE_HOLD
  - saturated bit indices SAT_HI/SAT_LO
  - width helper constants derived from the parameters
- One natural sub-module: sat_clamp.
  - Parametrised IN_WIDTH/OUT_WIDTH, combinational.
  - Signed clamp to [lo, hi] with hi/lo flags.
  - Used at S2 (ACC limits) and S3 (out_min/out_max).

Test Plan:
1. Reset: hold resetn=0 with adc_valid=1, release, keep adc_valid=1 for 10 cycles → dac_data=0, no dac_valid, saturated=0.
2. P-only: RUN, kp=4096, ki=0, setpoint=1000, adc_data=400, one adc_valid edge → dac_valid exactly 3 cycles later, dac_data=600.
3. Integral: kp=0, ki=4096, error=100, 5 edges spaced 4 cycles → dac_data 100,200,300,400,500.
4. Anti-windup: out_max=250, kp=0, ki=4096, error=100, 5 edges → outputs 100,200,250,250,250; saturated=2'b10 from the 3rd; acc frozen at 300. Then error=−100 → 200, saturated=0.
5. Hold and clear: with acc=500, mode=HOLD, 3 edges → no dac_valid, dac_data=500. Back to RUN, clear pulsed in the cycle the next sample is at S2, kp=4096, error=50 → dac_data=50.
6. OFF: mode=OFF, out_min=10, out_max=200, edges with error=1000 → dac_data=10 each sample, acc=0. Switch to RUN, ki=4096, kp=0, error=20 → first output 20.
